// File: rtl/shift_unit.sv
// Two-stage shift unit: S1 registers operand, opcode and the selected amount; S2 registers the result and flags.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise those opcodes are reported as illegal.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt_reg,
    input  logic [AW-1:0]    in_shamt_imm,
    input  logic             in_sel,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_illegal
);
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [WIDTH-1:0] s1_amt_q, s1_amt_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_zero_q, out_zero_d;
    logic             out_illegal_q, out_illegal_d;

    logic             s1_adv, accept, load2;
    logic [WIDTH:0]   sll_w, srl_w;
    logic signed [WIDTH:0] sra_w;
    logic [WIDTH-1:0] res;
    logic             res_c, res_ill;
`ifdef SHIFT_ROTATE_EN
    logic [AW-1:0]    rot_k, rot_nk;
`endif

    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;
    assign load2    = s1_adv && s1_valid_q;

    always_comb begin
        s1_valid_d = accept || (s1_valid_q && !s1_adv);
        s1_data_d  = s1_data_q;
        s1_op_d    = s1_op_q;
        s1_amt_d   = s1_amt_q;
        if (accept) begin
            s1_data_d = in_data;
            s1_op_d   = in_op;
            s1_amt_d  = in_sel ? in_shamt_reg : {{(WIDTH-AW){1'b0}}, in_shamt_imm};
        end
    end

    // The extra bit beside the data catches the last bit shifted out, so the
    // n = 0, n = WIDTH and n > WIDTH carry rules fall out of the shift itself.
    always_comb begin
        sll_w   = {1'b0, s1_data_q} << s1_amt_q;
        srl_w   = {s1_data_q, 1'b0} >> s1_amt_q;
        sra_w   = $signed({s1_data_q, 1'b0}) >>> s1_amt_q;
        res     = s1_data_q;
        res_c   = 1'b0;
        res_ill = 1'b0;
`ifdef SHIFT_ROTATE_EN
        rot_k   = s1_amt_q[AW-1:0];
        rot_nk  = -rot_k;
`endif
        case (s1_op_q)
            OP_SLL: begin res = sll_w[WIDTH-1:0]; res_c = sll_w[WIDTH]; end
            OP_SRL: begin res = srl_w[WIDTH:1];   res_c = srl_w[0];     end
            OP_SRA: begin res = sra_w[WIDTH:1];   res_c = sra_w[0];     end
`ifdef SHIFT_ROTATE_EN
            OP_ROL: begin
                res   = (s1_data_q << rot_k) | (s1_data_q >> rot_nk);
                res_c = (rot_k != '0) && res[0];
            end
            OP_ROR: begin
                res   = (s1_data_q >> rot_k) | (s1_data_q << rot_nk);
                res_c = (rot_k != '0) && res[WIDTH-1];
            end
`endif
            default: res_ill = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d   = s1_adv ? s1_valid_q : out_valid_q;
        out_data_d    = out_data_q;
        out_carry_d   = out_carry_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;
        if (load2) begin
            out_data_d    = res;
            out_carry_d   = res_c;
            out_zero_d    = (res == '0);
            out_illegal_d = res_ill;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_op_q       <= '0;
            s1_amt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_carry_q   <= 1'b0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_op_q       <= s1_op_d;
            s1_amt_q      <= s1_amt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_carry_q   <= out_carry_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_carry   = out_carry_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;
endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised, pipelined shift unit for the KGP_RISC execute stage. It replaces the fixed 32-bit two-way amount select and the combinational shifter with one block. The block selects the shift amount (register or immediate), performs logical, arithmetic or optional rotate shifts at any data width, and returns result, carry and zero flags over a valid/ready handshake with two cycles of latency.

## Interface
- WIDTH, 32, data width; power of two, 8..64.
- AW, $clog2(WIDTH), immediate shift-amount width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_data  in  WIDTH  operand to shift.
- in_shamt_reg  in  WIDTH  register-sourced amount; full width, unsigned.
- in_shamt_imm  in  AW  immediate amount, unsigned.
- in_sel  in  1  1 selects in_shamt_reg, 0 selects in_shamt_imm (zero-extended).
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; others illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted out.
- out_zero  out  1  out_data == 0.
- out_illegal  out  1  op was illegal or not compiled in.

## Operation
- Stage 1 (S1): on accept (in_valid && in_ready), register in_data, in_op and the selected amount. The amount is muxed before the register and zero-extended to WIDTH.
- Stage 2 (S2): compute from the S1 contents. Register out_data, out_carry, out_zero and out_illegal.
- Amount rules for amount n:
  - n = 0: data unchanged, carry 0, all ops.
  - 0 < n ≤ WIDTH-1: normal shift. Carry for SLL is in_data[WIDTH-n]. Carry for SRL and SRA is in_data[n-1].
  - n = WIDTH: SLL/SRL result 0. SLL carry is in_data[0]; SRL carry is in_data[WIDTH-1]. SRA result is all sign bits, carry is the sign bit.
  - n > WIDTH: SLL/SRL result 0, carry 0. SRA result is all sign bits, carry is the sign bit.
- Rotates (macro enabled):
  - Amount is n mod WIDTH.
  - ROL carry is result[0]; ROR carry is result[WIDTH-1].
  - When (n mod WIDTH) = 0: data unchanged, carry 0.
- Illegal op: out_data = in_data, carry 0, out_illegal 1.

## Timing
- Reset (rst low, asynchronous): both stage valids are 0. out_valid 0, out_data 0, out_carry 0, out_zero 0, out_illegal 0, in_ready 1.
- Reset asserted mid-operation discards all in-flight requests; nothing is output after release.
- Latency: a request accepted in cycle t is presented with out_valid = 1 in cycle t+2, provided there is no backpressure.
- Throughput: one request per cycle when out_ready is held high.
- Stall and ready rules:
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv. This is combinational from out_ready; no combinational path from in_valid.
- While out_valid && !out_ready, all out_* signals hold stable.
- A new request may be accepted in the same cycle as S1 advances to S2 and S2 drains.
- Zero-bubble requirement: with out_ready low, the unit holds two requests and then drops in_ready. The cycle out_ready rises, in_ready also rises.

## Configuration
- SHIFT_ROTATE_EN defined: ROL/ROR implemented as described.
- SHIFT_ROTATE_EN undefined: opcodes 011/100 are treated as illegal (pass-through, out_illegal 1), and no rotate logic is synthesised.

## Test plan
- Reset: hold rst low with in_valid=1 → out_valid 0, in_ready 1, all outputs 0. Release → first accepted request appears exactly 2 cycles later.
- Amount select, WIDTH=32: in_data=0x80000001, SRA.
  - in_sel=1, in_shamt_reg=4 → out_data 0xF8000000, carry 0.
  - in_sel=0, in_shamt_imm=1 → out_data 0xC0000000, carry 1.
- Boundaries: SLL 0x00000001 by 32 → data 0, carry 1. SLL by 33 → data 0, carry 0. SRL 0x80000000 by 0 → unchanged, carry 0, zero 0. SRA 0x80000000 by 100 → 0xFFFFFFFF, carry 1.
- Backpressure: 4 back-to-back SLL-by-1 requests with out_ready low for 5 cycles. Expect in_ready low after 2 accepts, out_* stable during the stall, then all 4 results in order with no loss or duplication.
- Rotate, macro on: ROL 0x80000001 by 33 → 0x00000003, carry 1. Macro off → 0x80000001, out_illegal 1.
- Width sweep: WIDTH=8. SRA 0x90 by 3 → 0xF2, carry 0. Op 111 → out_illegal 1, data unchanged.
